piso_bidi_tx: RTL and testbench
===============================

Name: piso_bidi_tx

Overview:
Parallel-in serial-out transmitter with selectable shift direction. It is the sending end of our serial bit-stream links and feeds the SISO bidirectional shift register and other serial receivers. It accepts a WIDTH-bit word on a one-cycle load strobe and shifts it out one bit per clock, MSB-first or LSB-first. Status outputs report when a frame is in progress and when it completes.

Parameters:
WIDTH, 4, frame length in bits; legal range WIDTH >= 2.

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous reset, active-low (0 = reset)
load  input  1  start-frame strobe, sampled on clk rising edge
Data_in  input  WIDTH  parallel word to transmit
I_D  input  1  direction: 1 = MSB-first, 0 = LSB-first
Salida  output  1  serial data out, registered
valid  output  1  high while Salida carries a frame bit
busy  output  1  high while a frame is in progress
done  output  1  one-cycle pulse after the last bit of a frame is driven

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE
  - shift register=0, latched direction=0, bit counter=0
  - Salida=0, valid=0, busy=0, done=0
  - Reset is effective immediately and aborts any frame in progress; no done pulse is generated.
- Registered state: FSM {IDLE, SHIFT}, shreg[WIDTH-1:0], dir, cnt[$clog2(WIDTH)-1:0].
- IDLE:
  - On an edge with load=0: valid<=0 and done<=0. Salida holds its last value.
  - On an edge with load=1: shreg<=Data_in, dir<=I_D, cnt<=0, busy<=1, state<=SHIFT. valid stays 0 and Salida is unchanged.
- SHIFT, on every edge:
  - dir=1: Salida<=shreg[WIDTH-1], then shreg shifts left with zero fill.
  - dir=0: Salida<=shreg[0], then shreg shifts right with zero fill.
  - valid<=1 and cnt<=cnt+1.
  - When cnt==WIDTH-1 on this edge (last bit): state<=IDLE, busy<=0, done<=1.
- Latency:
  - Load sampled at edge k.
  - Bit i (i=0..WIDTH-1) appears on Salida after edge k+1+i.
  - valid is high for exactly WIDTH consecutive cycles.
  - done is high for one cycle, coinciding with the cycle in which the last bit is on Salida (after edge k+WIDTH).
  - busy is high from after edge k until edge k+WIDTH.
- After the frame: on the next edge without a new load, valid<=0 and done<=0. Salida keeps the last bit and must be qualified by valid.
- Boundary conditions:
  - load while busy, including on the last-bit edge: ignored, no queuing.
  - Back-to-back frames: a load sampled in the cycle after done (state IDLE) is accepted. The minimum frame period is WIDTH+1 cycles.
  - Data_in and I_D are sampled only on the accepting edge. Changes to them mid-frame have no effect.
  - Pairing with the receiver: I_D=1 on both ends reproduces the word in receiver register order; the same holds for I_D=0 on both ends.
  - Counter wrap: cnt never exceeds WIDTH-1 and is cleared on each accepted load.

Test Plan:
1. Reset: hold rst=0 with load=1 and random inputs for 3 cycles -> Salida=0, valid=0, busy=0, done=0 throughout. Release rst -> outputs stay 0 until load is sampled.
2. MSB-first, WIDTH=4: load=1 with Data_in=4'b1011, I_D=1 at edge 0 -> Salida=1,0,1,1 after edges 1-4; valid=1 for those 4 cycles; done=1 only after edge 4; busy=1 after edges 0-3.
3. LSB-first: Data_in=4'b1011, I_D=0 -> Salida=1,1,0,1. Then toggle I_D and Data_in mid-frame -> the sequence is unchanged.
4. Load while busy: second load with Data_in=4'b0000 at edges 2 and 4 of a 4'b1111 frame -> Salida=1,1,1,1, only one done pulse, no second frame.
5. Back-to-back: load 4'b0110 (I_D=1), then load 4'b1001 (I_D=0) in the cycle after done -> valid stream 0,1,1,0 then 1,0,0,1, with a single valid=0 gap cycle between frames.
6. Reset mid-frame: assert rst=0 asynchronously between edges 2 and 3 -> all outputs go 0 immediately; no done pulse. A later load transmits a fresh frame correctly. Loopback into the receiver with 16 random words per direction -> receiver register equals Data_in.

Source files
------------

// File: rtl/piso_bidi_tx.sv
// -----------------------------------------------------------------------------
// piso_bidi_tx
// Parallel-in serial-out transmitter with selectable shift direction.
// A WIDTH-bit word is captured on a one-cycle load strobe and shifted out one
// bit per clock, MSB-first (I_D=1) or LSB-first (I_D=0).
//
// Ports:
//   clk     : system clock, rising-edge active
//   rst     : asynchronous reset, active-low
//   load    : start-frame strobe, honoured only while idle
//   Data_in : parallel word to transmit (sampled on the accepting edge only)
//   I_D     : direction, 1 = MSB-first, 0 = LSB-first (sampled with Data_in)
//   Salida  : serial data out, registered; qualify with valid
//   valid   : high while Salida carries a frame bit
//   busy    : high while a frame is in progress
//   done    : one-cycle pulse in the cycle the last bit is on Salida
// -----------------------------------------------------------------------------
module piso_bidi_tx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] Data_in,
    input  logic             I_D,
    output logic             Salida,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] shreg_r, shreg_s;
    logic             dir_r, dir_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             salida_r, salida_s;
    logic             valid_r, valid_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;

    // Bit that leaves the register this cycle for the given direction.
    function automatic logic out_bit(input logic [WIDTH-1:0] word, input logic dir);
        out_bit = dir ? word[WIDTH-1] : word[0];
    endfunction

    // Register contents after one shift, zero-filled on the vacated end.
    function automatic logic [WIDTH-1:0] shifted(input logic [WIDTH-1:0] word,
                                                 input logic dir);
        shifted = dir ? {word[WIDTH-2:0], 1'b0} : {1'b0, word[WIDTH-1:1]};
    endfunction

    // Next-state and next-output logic; every register holds unless updated.
    always_comb begin
        state_s  = state_r;
        shreg_s  = shreg_r;
        dir_s    = dir_r;
        cnt_s    = cnt_r;
        salida_s = salida_r;
        valid_s  = valid_r;
        busy_s   = busy_r;
        done_s   = done_r;
        case (state_r)
            IDLE: begin
                // Salida deliberately holds its last value while idle.
                valid_s = 1'b0;
                done_s  = 1'b0;
                if (load) begin
                    shreg_s = Data_in;
                    dir_s   = I_D;
                    cnt_s   = CNT_ZERO;
                    busy_s  = 1'b1;
                    state_s = SHIFT;
                end else begin
                    busy_s  = 1'b0;
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                // load is ignored here, including on the last-bit edge.
                salida_s = out_bit(shreg_r, dir_r);
                shreg_s  = shifted(shreg_r, dir_r);
                valid_s  = 1'b1;
                if (cnt_r == CNT_LAST) begin
                    cnt_s   = CNT_ZERO;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    state_s = IDLE;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                    busy_s  = 1'b1;
                    done_s  = 1'b0;
                    state_s = SHIFT;
                end
            end
            default: begin
                // Unreachable encoding: drop back to a quiet idle.
                state_s  = IDLE;
                shreg_s  = {WIDTH{1'b0}};
                dir_s    = 1'b0;
                cnt_s    = CNT_ZERO;
                salida_s = 1'b0;
                valid_s  = 1'b0;
                busy_s   = 1'b0;
                done_s   = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame without a done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= IDLE;
            shreg_r  <= {WIDTH{1'b0}};
            dir_r    <= 1'b0;
            cnt_r    <= CNT_ZERO;
            salida_r <= 1'b0;
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            shreg_r  <= shreg_s;
            dir_r    <= dir_s;
            cnt_r    <= cnt_s;
            salida_r <= salida_s;
            valid_r  <= valid_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
        end
    end

    assign Salida = salida_r;
    assign valid  = valid_r;
    assign busy   = busy_r;
    assign done   = done_r;

endmodule

// File: tb/tb_piso_bidi_tx.sv
// -----------------------------------------------------------------------------
// tb_piso_bidi_tx
// Directed self-checking bench for piso_bidi_tx (WIDTH=4) with a small
// serial-receiver model used for the random loopback section.
// -----------------------------------------------------------------------------
module tb_piso_bidi_tx;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             load;
    logic [WIDTH-1:0] Data_in;
    logic             I_D;
    logic             Salida;
    logic             valid;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    piso_bidi_tx #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .Data_in (Data_in),
        .I_D     (I_D),
        .Salida  (Salida),
        .valid   (valid),
        .busy    (busy),
        .done    (done)
    );

    // Single comparison point: counts and reports mismatches.
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One frame: accept edge then WIDTH shift edges. seq lists the expected
    // serial bits in time order, left to right. mode 1 scrambles Data_in/I_D
    // mid-frame, mode 2 pulses load with 0000 on shift edges 2 and 4.
    task automatic run_frame(input string tag, input logic [WIDTH-1:0] data,
                             input logic dir, input logic [WIDTH-1:0] seq, input int mode);
        load    = 1'b1;
        Data_in = data;
        I_D     = dir;
        step();
        load = 1'b0;
        check_val({tag, "_accept"}, 32'({valid, busy, done}), 32'(3'b010));
        for (int i = 0; i < WIDTH; i++) begin
            if (mode == 1) begin
                Data_in = ~Data_in;
                I_D     = ~I_D;
            end
            if (mode == 2 && (i == 1 || i == 3)) begin
                load    = 1'b1;
                Data_in = 4'b0000;
            end
            step();
            load = 1'b0;
            check_val($sformatf("%s_bit%0d", tag, i),
                      32'({Salida, valid, busy, done}),
                      32'({seq[WIDTH-1-i], 1'b1, (i != WIDTH-1), (i == WIDTH-1)}));
        end
    endtask

    logic [WIDTH-1:0] rx;
    logic [WIDTH-1:0] word;
    logic             wdir;
    logic             seen_done;

    initial begin
        // 1. Reset held with load asserted and random inputs.
        rst     = 1'b0;
        load    = 1'b1;
        Data_in = 4'($urandom);
        I_D     = 1'($urandom);
        for (int i = 0; i < 3; i++) begin
            step();
            Data_in = 4'($urandom);
            I_D     = 1'($urandom);
            check_val($sformatf("reset_hold%0d", i), 32'({Salida, valid, busy, done}), 32'(4'b0000));
        end
        rst  = 1'b1;
        load = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check_val($sformatf("post_reset%0d", i), 32'({Salida, valid, busy, done}), 32'(4'b0000));
        end

        // 2. MSB-first 1011 -> 1,0,1,1; then idle: valid/done drop, Salida holds.
        run_frame("msb", 4'b1011, 1'b1, 4'b1011, 0);
        step();
        check_val("msb_idle", 32'({Salida, valid, busy, done}), 32'(4'b1000));

        // 3. LSB-first 1011 -> 1,1,0,1, then again with inputs scrambled mid-frame.
        run_frame("lsb", 4'b1011, 1'b0, 4'b1101, 0);
        step();
        check_val("lsb_idle", 32'({Salida, valid, busy, done}), 32'(4'b1000));
        run_frame("lsb_scr", 4'b1011, 1'b0, 4'b1101, 1);
        step();
        check_val("lsb_scr_idle", 32'({Salida, valid, busy, done}), 32'(4'b1000));

        // 4. Loads while busy (edges 2 and 4) are ignored: no second frame.
        run_frame("busy_ld", 4'b1111, 1'b1, 4'b1111, 2);
        for (int i = 0; i < 3; i++) begin
            step();
            check_val($sformatf("busy_ld_idle%0d", i), 32'({Salida, valid, busy, done}), 32'(4'b1000));
        end

        // 5. Back-to-back: second load in the cycle after done.
        run_frame("b2b_a", 4'b0110, 1'b1, 4'b0110, 0);
        run_frame("b2b_b", 4'b1001, 1'b0, 4'b1001, 0);
        step();
        check_val("b2b_idle", 32'({Salida, valid, busy, done}), 32'(4'b1000));

        // 6. Asynchronous reset between edges 2 and 3 of a frame.
        load    = 1'b1;
        Data_in = 4'b1011;
        I_D     = 1'b1;
        step();
        load = 1'b0;
        step();
        step();
        check_val("abort_pre", 32'({Salida, valid, busy, done}), 32'(4'b0110));
        #2;
        rst = 1'b0;
        #1;
        check_val("abort_now", 32'({Salida, valid, busy, done}), 32'(4'b0000));
        step();
        check_val("abort_hold", 32'({Salida, valid, busy, done}), 32'(4'b0000));
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val($sformatf("abort_after%0d", i), 32'({Salida, valid, busy, done}), 32'(4'b0000));
        end
        run_frame("fresh", 4'b1100, 1'b0, 4'b0011, 0);
        step();

        // Loopback into a receiver model, 16 random words per direction.
        for (int k = 0; k < 32; k++) begin
            word      = 4'($urandom);
            wdir      = (k < 16);
            rx        = '0;
            seen_done = 1'b0;
            load      = 1'b1;
            Data_in   = word;
            I_D       = wdir;
            step();
            load = 1'b0;
            for (int c = 0; c < 2 * WIDTH + 2 && !seen_done; c++) begin
                step();
                if (valid) begin
                    rx = wdir ? {rx[WIDTH-2:0], Salida} : {Salida, rx[WIDTH-1:1]};
                end
                if (done) begin
                    seen_done = 1'b1;
                end
            end
            check_val($sformatf("loop%0d_done", k), 32'(seen_done), 32'(1'b1));
            check_val($sformatf("loop%0d_word", k), 32'(rx), 32'(word));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
